// File: rtl/sel_mux_skid_pkg.sv
// sel_mux_skid_pkg: shared pipeline types and the N:1 select helper
//   REG_IDX_W  default select width (register-destination index)
//   skid_st_e  skid buffer occupancy state
//   sel_word   returns {err, data} for a select over up to SEL_MAX_N channels of up to SEL_MAX_W bits
package sel_mux_skid_pkg;
   localparam int REG_IDX_W = 5;
   localparam int SEL_MAX_W = 64;
   localparam int SEL_MAX_N = 16;
   typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_st_e;
   // sel is checked at full width first, so only the low index bits are needed afterwards
   function automatic logic [SEL_MAX_W:0] sel_word(input logic [SEL_MAX_N-1:0][SEL_MAX_W-1:0] d,
                                                   input logic [31:0] sel, input logic [31:0] n);
      return (sel < n) ? {1'b0, d[sel[3:0]]} : {1'b1, {SEL_MAX_W{1'b0}}};
   endfunction
endpackage

// File: rtl/sel_mux_skid_comb.sv
// sel_mux_comb: combinational N:1 select with range check
//   in_data  packed channels, channel k at [k*WIDTH +: WIDTH]
//   in_sel   channel index
//   data     selected word, zero when out of range
//   err      in_sel >= NUM_IN
module sel_mux_comb
   import sel_mux_skid_pkg::*;
#(
   parameter int WIDTH  = REG_IDX_W,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [WIDTH-1:0]        data,
   output logic                    err
);
   logic [SEL_MAX_N-1:0][SEL_MAX_W-1:0] ch;
   logic [SEL_MAX_W:0]                  w;
   logic                                unused_w;
   always_comb begin
      ch = '0;
      for (int k = 0; k < NUM_IN; k++) ch[k][WIDTH-1:0] = in_data[k*WIDTH +: WIDTH];
      w = sel_word(ch, 32'(in_sel), NUM_IN);
   end
   assign data     = w[WIDTH-1:0];
   assign err      = w[SEL_MAX_W];
   assign unused_w = ^w;
endmodule

// File: rtl/sel_mux_skid.sv
// sel_mux_skid: registered N:1 select with valid/ready handshake and two-entry skid buffer
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data, in_sel     packed channels and channel index, sampled on accept
//   in_valid, in_ready  input handshake; in_ready is a register
//   flush               synchronous discard of all held beats
//   out_data, out_err   selected word and out-of-range flag, registered
//   out_valid, out_ready output handshake
module sel_mux_skid
   import sel_mux_skid_pkg::*;
#(
   parameter int WIDTH  = REG_IDX_W,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);
   skid_st_e         st, nst;
   logic [WIDTH-1:0] sel_data, s_data;
   logic             sel_err, s_err, acc, xfer;
   sel_mux_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
      .in_data(in_data), .in_sel(in_sel), .data(sel_data), .err(sel_err)
   );
   assign acc  = in_valid && in_ready;
   assign xfer = out_valid && out_ready;
   always_comb
      nst = flush            ? EMPTY :
            (st == EMPTY)    ? (acc ? ONE : EMPTY) :
            (st == ONE)      ? ((acc && !xfer) ? FULL : (!acc && xfer) ? EMPTY : ONE) :
                               (xfer ? ONE : FULL);
   // S's valid bit is implied by st == FULL; M's valid bit is out_valid
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st        <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
         s_data    <= '0;
         s_err     <= 1'b0;
      end else begin
         st        <= nst;
         in_ready  <= nst != FULL;
         out_valid <= nst != EMPTY;
         if (!flush) begin
            if (st == FULL && xfer) begin
               out_data <= s_data;
               out_err  <= s_err;
            end else if (acc && (st == EMPTY || xfer)) begin
               out_data <= sel_data;
               out_err  <= sel_err;
            end
            if (acc && st == ONE && !xfer) begin
               s_data <= sel_data;
               s_err  <= sel_err;
            end
         end
      end
endmodule

// File: doc/sel_mux_skid.md
# sel_mux_skid

Parametrised, registered N:1 select multiplexer with a valid/ready handshake and a two-entry skid buffer. It replaces fixed-width 2:1 combinational selects in the pipeline wherever a selected field crosses a stage boundary under backpressure, for example the register-destination select feeding EX/MEM. Examples are destination register number, forwarding source and write-back value. One selected word enters per accepted input beat. Words leave in order, one cycle later, with full throughput while `out_ready` stays high.

## Interface
- `WIDTH`, default 5: bit width of each data channel.
- `NUM_IN`, default 4: number of input channels, 2..16.
- `SEL_W`, default `$clog2(NUM_IN)`: select width.
- `clk` input, 1 bit: the only clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to `clk`.
- `in_data` input, NUM_IN*WIDTH bits: packed channels. Channel k occupies bits [k*WIDTH +: WIDTH].
- `in_sel` input, SEL_W bits: channel index.
- `in_valid` input, 1 bit: the input beat is present.
- `in_ready` output, 1 bit: the block can accept a beat. Driven directly from a register.
- `flush` input, 1 bit: synchronous discard of all held beats.
- `out_data` output, WIDTH bits: the selected word. Driven directly from a register.
- `out_err` output, 1 bit: the beat was selected with `in_sel` ≥ NUM_IN.
- `out_valid` output, 1 bit: the output beat is present.
- `out_ready` input, 1 bit: the consumer accepts the beat.

## Operation
- Accept: the input beat is accepted when `in_valid && in_ready`. Output transfer: when `out_valid && out_ready`.
- Selection happens at accept time.
  - If `in_sel` < NUM_IN, the captured word is `in_data[in_sel*WIDTH +: WIDTH]` with err=0.
  - Otherwise the captured word is all zeros with err=1.
- Storage is a main register (M), which drives the outputs, and a skid register (S). Each holds {data, err, valid}.
- States and transitions:
  - EMPTY: M and S both invalid. On accept, load M and go to ONE.
  - ONE: M valid, S invalid.
    - accept and transfer: reload M, stay in ONE.
    - accept without transfer: load S, go to FULL.
    - transfer without accept: go to EMPTY.
  - FULL: M and S both valid, `in_ready`=0.
    - transfer: move S into M, go to ONE. No accept is possible in FULL.
- `in_ready` is registered and equals "next state ≠ FULL". It is never combinationally dependent on `out_ready`.
- Flush has priority over every other event in the same cycle.
  - Next state is EMPTY and any concurrent input beat is discarded.
  - `in_ready`=1 on the following cycle.
  - A transfer that coincides with flush still counts as delivered to the consumer.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_err`=0, `in_ready`=1, state EMPTY.
- Reset asserted mid-operation clears all beats immediately and asynchronously. No output beat is produced for any beat in flight.
- Latency: a beat accepted on edge n appears on `out_data`/`out_valid` after edge n (visible in cycle n+1).
- Throughput: 1 beat/cycle while `out_ready`=1.
- Backpressure: when `out_ready` drops, at most one further beat is absorbed into S. `in_ready` falls in the cycle after FULL is entered.
- Simultaneous events:
  - Accept and transfer in ONE: M is updated with no bubble.
  - Transfer in FULL with `in_valid`=1: the input is not accepted that cycle. It is accepted the next cycle, when `in_ready`=1.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_err` hold stable.

## Structure
- Shared pipeline package holds:
  - `REG_IDX_W` = 5, the default WIDTH.
  - the state type `skid_st_e` {EMPTY, ONE, FULL}.
  - a `sel_word` function returning {err, data} for a given sel/NUM_IN.
- One sub-module, `sel_mux_comb`: the pure combinational N:1 select with range check. The top instantiates it once, on the input side.

## Test plan
- Reset then stream: hold `out_ready`=1 and apply NUM_IN=4 and WIDTH=5 beats with sel=0,1,2,3 over data {5'h01,5'h0A,5'h15,5'h1F}. The output must be 01,0A,15,1F on consecutive cycles, 1 cycle after each accept, with `out_err`=0.
- Backpressure: drop `out_ready` for 3 cycles during the stream. Exactly one extra beat must be absorbed, `in_ready` must go 0, no beat may be lost, and order must be preserved after `out_ready` returns.
- Out-of-range select: build with NUM_IN=3 and apply sel=3 with all channels 5'h1F. The output must be 5'h00 with `out_err`=1.
- Flush in FULL with `in_valid`=1: `out_valid`=0 next cycle, `in_ready`=1, and the flushed and concurrent beats never appear.
- Async reset in mid-stream (FULL state, between edges): `out_valid`=0, `out_data`=0 and `in_ready`=1 immediately. After release, the first new beat appears with 1-cycle latency.
- Randomised valid/ready over 10k cycles with WIDTH=32, NUM_IN=8: a scoreboard must match every accepted selected word, in order.
